// File: rtl/stream_input_fifo_if.sv
// Byte stream bundle between the serial receiver, the input FIFO and the interpreter.
// overflow_count exists only when STREAM_INPUT_FIFO_STATS_EN is defined.
interface stream_input_fifo_if #(
   parameter int DEPTH_LOG2 = 5
);
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                ready_n;
   logic [7:0]          unicode;
   logic                unicode_available;
   logic                rts_n;
   logic [DEPTH_LOG2:0] fifo_level;
   logic                overflow;
`ifdef STREAM_INPUT_FIFO_STATS_EN
   logic [15:0]         overflow_count;
`endif

   modport slave (
      input  rx_data, rx_valid, ready_n,
      output unicode, unicode_available, rts_n, fifo_level, overflow
`ifdef STREAM_INPUT_FIFO_STATS_EN
      , output overflow_count
`endif
   );

   modport master (
      output rx_data, rx_valid, ready_n,
      input  unicode, unicode_available, rts_n, fifo_level, overflow
`ifdef STREAM_INPUT_FIFO_STATS_EN
      , input overflow_count
`endif
   );
endinterface

// File: rtl/stream_input_fifo.sv
// Input byte FIFO: buffers received bytes, replays them as paced one-cycle strobes
// and drives RTS with watermark hysteresis. Optional macro: STREAM_INPUT_FIFO_STATS_EN.
module stream_input_fifo #(
   parameter int DEPTH_LOG2     = 5,
   parameter int HIGH_WATERMARK = 24,
   parameter int LOW_WATERMARK  = 8
) (
   input logic                clk,
   input logic                reset,
   stream_input_fifo_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   lvl_t;

   localparam lvl_t FULL_LVL = lvl_t'(DEPTH);
   localparam lvl_t ZERO_LVL = lvl_t'(0);
   localparam lvl_t HIGH_LVL = lvl_t'(HIGH_WATERMARK);
   localparam lvl_t LOW_LVL  = lvl_t'(LOW_WATERMARK);

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } state_t;

   logic [7:0] mem_r [DEPTH];
   ptr_t       wr_ptr_r;
   ptr_t       rd_ptr_r;
   lvl_t       level_r;
   state_t     state_r;
   logic [7:0] unicode_r;
   logic       avail_r;
   logic       rts_n_r;
   logic       overflow_r;

   logic       pop_s;
   logic       accept_s;
   logic       drop_s;
   lvl_t       level_after_pop_s;
   lvl_t       next_level_s;
   logic       rts_n_next_s;

   // Pop/push arbitration; fullness is judged after this edge's pop.
   always_comb begin
      pop_s             = 1'b0;
      accept_s          = 1'b0;
      drop_s            = 1'b0;
      level_after_pop_s = level_r;
      next_level_s      = level_r;
      rts_n_next_s      = rts_n_r;
      if ((state_r == ST_WAIT) && (level_r != ZERO_LVL) && !bus.ready_n) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      level_after_pop_s = level_r - lvl_t'(pop_s);
      if (bus.rx_valid) begin
         accept_s = (level_after_pop_s != FULL_LVL);
         drop_s   = (level_after_pop_s == FULL_LVL);
      end else begin
         accept_s = 1'b0;
         drop_s   = 1'b0;
      end
      next_level_s = level_after_pop_s + lvl_t'(accept_s);
      if (next_level_s >= HIGH_LVL) begin
         rts_n_next_s = 1'b1;
      end else if (next_level_s <= LOW_LVL) begin
         rts_n_next_s = 1'b0;
      end else begin
         rts_n_next_s = rts_n_r;
      end
   end

   // Storage array, left unreset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= bus.rx_data;
      end
   end

   // Pointers, level, flow control, sticky overflow and the read sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= ptr_t'(0);
         rd_ptr_r   <= ptr_t'(0);
         level_r    <= ZERO_LVL;
         state_r    <= ST_WAIT;
         unicode_r  <= 8'h00;
         avail_r    <= 1'b0;
         rts_n_r    <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_r + ptr_t'(accept_s);
         rd_ptr_r   <= rd_ptr_r + ptr_t'(pop_s);
         level_r    <= next_level_s;
         rts_n_r    <= rts_n_next_s;
         overflow_r <= overflow_r | drop_s;
         case (state_r)
            ST_WAIT: begin
               if (pop_s) begin
                  unicode_r <= mem_r[rd_ptr_r];
                  avail_r   <= 1'b1;
                  state_r   <= ST_PRESENT;
               end else begin
                  avail_r   <= 1'b0;
                  state_r   <= ST_WAIT;
               end
            end
            ST_PRESENT: begin
               avail_r <= 1'b0;
               state_r <= ST_GAP;
            end
            // GAP lets the interpreter's registered ready_n catch up before the next pop
            ST_GAP: begin
               avail_r <= 1'b0;
               state_r <= ST_WAIT;
            end
            default: begin
               avail_r <= 1'b0;
               state_r <= ST_WAIT;
            end
         endcase
      end
   end

`ifdef STREAM_INPUT_FIFO_STATS_EN
   logic [15:0] overflow_count_r;

   // Saturating count of dropped bytes.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_count_r <= 16'h0000;
      end else if (drop_s && (overflow_count_r != 16'hFFFF)) begin
         overflow_count_r <= overflow_count_r + 16'h0001;
      end else begin
         overflow_count_r <= overflow_count_r;
      end
   end

   assign bus.overflow_count = overflow_count_r;
`endif

   assign bus.unicode           = unicode_r;
   assign bus.unicode_available = avail_r;
   assign bus.rts_n             = rts_n_r;
   assign bus.fifo_level        = level_r;
   assign bus.overflow          = overflow_r;
endmodule

// File: tb/tb_stream_input_fifo.sv
// Directed self-checking bench for stream_input_fifo (default depth 32, watermarks 24/8).
module tb_stream_input_fifo;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] got_q [$];

   stream_input_fifo_if #(.DEPTH_LOG2(5)) bus ();

   stream_input_fifo #(
      .DEPTH_LOG2(5), .HIGH_WATERMARK(24), .LOW_WATERMARK(8)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // Record every delivered byte shortly after the falling edge.
   always @(negedge clk) begin
      #2;
      if (bus.unicode_available === 1'b1) got_q.push_back(bus.unicode);
   end

   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      bus.rx_data  = d;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_q(input int n, input int budget, output bit ok);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (got_q.size() >= n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
      checks++; if (bus.unicode_available !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b want 0", bus.unicode_available); end
      checks++; if (bus.unicode !== 8'h00) begin errors++; $display("FAIL reset_unicode: got %h want 00", bus.unicode); end
      checks++; if (bus.fifo_level !== 6'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
      checks++; if (bus.rts_n !== 1'b0) begin errors++; $display("FAIL reset_rts: got %b want 0", bus.rts_n); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
`ifdef STREAM_INPUT_FIFO_STATS_EN
      checks++; if (bus.overflow_count !== 16'd0) begin errors++; $display("FAIL reset_ovf_count: got %0d want 0", bus.overflow_count); end
`endif
   endtask

   task automatic test_basic();
      int n;
      apply_reset();
      bus.ready_n = 1'b0;
      got_q.delete();
      bus.rx_data = 8'h41; bus.rx_valid = 1'b1;
      @(negedge clk);                       // first write edge done
      bus.rx_data = 8'h42;
      checks++; if (bus.unicode_available !== 1'b0) begin errors++; $display("FAIL basic_no_early_strobe: got %b want 0", bus.unicode_available); end
      checks++; if (bus.fifo_level !== 6'd1) begin errors++; $display("FAIL basic_level_after_write: got %0d want 1", bus.fifo_level); end
      @(negedge clk);                       // pop of 0x41, write of 0x42
      bus.rx_valid = 1'b0;
      checks++; if (bus.unicode_available !== 1'b1 || bus.unicode !== 8'h41) begin errors++; $display("FAIL basic_first_strobe: got avail=%b data=%h want avail=1 data=41", bus.unicode_available, bus.unicode); end
      n = 0;
      do begin @(negedge clk); n++; end while (bus.unicode_available !== 1'b1 && n < 10);
      checks++; if (n !== 3) begin errors++; $display("FAIL basic_strobe_spacing: got %0d cycles want 3", n); end
      checks++; if (bus.unicode !== 8'h42) begin errors++; $display("FAIL basic_second_byte: got %h want 42", bus.unicode); end
      idle(4);
      checks++; if (bus.fifo_level !== 6'd0) begin errors++; $display("FAIL basic_level_drained: got %0d want 0", bus.fifo_level); end
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL basic_strobe_count: got %0d want 2", got_q.size()); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad = 0;
      apply_reset();
      bus.ready_n = 1'b1;
      got_q.delete();
      for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
      idle(5);
      checks++; if (bus.fifo_level !== 6'd5) begin errors++; $display("FAIL bp_level_held: got %0d want 5", bus.fifo_level); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL bp_no_strobe: got %0d strobes want 0", got_q.size()); end
      bus.ready_n = 1'b0;
      wait_q(2, 30, ok);
      bus.ready_n = 1'b1;
      checks++; if (!ok) begin errors++; $display("FAIL bp_release_timeout: got %0d strobes want 2", got_q.size()); end
      idle(12);
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bp_stall_count: got %0d want 2", got_q.size()); end
      checks++; if (bus.fifo_level !== 6'd3) begin errors++; $display("FAIL bp_stall_level: got %0d want 3", bus.fifo_level); end
      bus.ready_n = 1'b0;
      wait_q(5, 40, ok);
      idle(4);
      for (int i = 0; i < 5; i++) if (i >= got_q.size() || got_q[i] !== 8'(8'h10 + i)) bad++;
      checks++; if (!ok || got_q.size() !== 5 || bad != 0) begin errors++; $display("FAIL bp_order: got %0d bytes with %0d wrong, want 5 in order", got_q.size(), bad); end
      checks++; if (bus.fifo_level !== 6'd0) begin errors++; $display("FAIL bp_final_level: got %0d want 0", bus.fifo_level); end
   endtask

   task automatic test_watermarks();
      int c = 0;
      int early = 0;
      apply_reset();
      bus.ready_n = 1'b1;
      for (int i = 0; i < 23; i++) push(8'(i));
      checks++; if (bus.rts_n !== 1'b0) begin errors++; $display("FAIL wm_rts_at_23: got %b want 0", bus.rts_n); end
      push(8'd23);
      checks++; if (bus.rts_n !== 1'b1 || bus.fifo_level !== 6'd24) begin errors++; $display("FAIL wm_rts_at_24: got rts=%b level=%0d want rts=1 level=24", bus.rts_n, bus.fifo_level); end
      for (int i = 24; i < 32; i++) push(8'(i));
      checks++; if (bus.rts_n !== 1'b1 || bus.fifo_level !== 6'd32) begin errors++; $display("FAIL wm_rts_at_32: got rts=%b level=%0d want rts=1 level=32", bus.rts_n, bus.fifo_level); end
      bus.ready_n = 1'b0;
      while (bus.fifo_level !== 6'd8 && c < 200) begin
         @(negedge clk);
         c++;
         if (bus.fifo_level > 6'd8 && bus.rts_n !== 1'b1) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL wm_hysteresis: got %0d cycles with rts=0 above level 8, want 0", early); end
      checks++; if (bus.fifo_level !== 6'd8 || bus.rts_n !== 1'b0) begin errors++; $display("FAIL wm_rts_low: got rts=%b level=%0d want rts=0 level=8", bus.rts_n, bus.fifo_level); end
   endtask

   task automatic test_overflow();
      bit ok;
      int bad = 0;
      apply_reset();
      bus.ready_n = 1'b1;
      got_q.delete();
      for (int i = 0; i < 32; i++) push(8'(i));
      checks++; if (bus.overflow !== 1'b0 || bus.fifo_level !== 6'd32) begin errors++; $display("FAIL ovf_full_no_flag: got ovf=%b level=%0d want ovf=0 level=32", bus.overflow, bus.fifo_level); end
      for (int i = 0; i < 3; i++) push(8'hEE);
      checks++; if (bus.overflow !== 1'b1 || bus.fifo_level !== 6'd32) begin errors++; $display("FAIL ovf_flag: got ovf=%b level=%0d want ovf=1 level=32", bus.overflow, bus.fifo_level); end
`ifdef STREAM_INPUT_FIFO_STATS_EN
      checks++; if (bus.overflow_count !== 16'd3) begin errors++; $display("FAIL ovf_count: got %0d want 3", bus.overflow_count); end
`endif
      bus.ready_n = 1'b0;
      wait_q(32, 200, ok);
      idle(8);
      for (int i = 0; i < 32; i++) if (i >= got_q.size() || got_q[i] !== 8'(i)) bad++;
      checks++; if (!ok || got_q.size() !== 32 || bad != 0) begin errors++; $display("FAIL ovf_drain: got %0d bytes with %0d wrong, want 0..31 only", got_q.size(), bad); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      bus.ready_n = 1'b1;
      for (int i = 0; i < 11; i++) push(8'(8'hA0 + i));
      bus.ready_n = 1'b0;
      while (bus.unicode_available !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      checks++; if (bus.unicode_available !== 1'b1 || bus.fifo_level !== 6'd10) begin errors++; $display("FAIL rst_mid_setup: got avail=%b level=%0d want avail=1 level=10", bus.unicode_available, bus.fifo_level); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      got_q.delete();
      checks++; if (bus.unicode_available !== 1'b0 || bus.fifo_level !== 6'd0 || bus.rts_n !== 1'b0 || bus.overflow !== 1'b0) begin
         errors++; $display("FAIL rst_mid_state: got avail=%b level=%0d rts=%b ovf=%b want 0 0 0 0", bus.unicode_available, bus.fifo_level, bus.rts_n, bus.overflow);
      end
      idle(20);
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rst_mid_stale: got %0d strobes want 0", got_q.size()); end
   endtask

   task automatic test_stream();
      bit ok;
      int bad = 0;
      int exp_q [$];
      // Continuous stream: FIFO full after edge 47, then only writes paired with a pop survive.
      apply_reset();
      bus.ready_n = 1'b0;
      got_q.delete();
      for (int k = 0; k < 100; k++) begin
         push(8'(k));
         if (k < 48 || (k % 3) == 1) exp_q.push_back(k);
      end
      wait_q(exp_q.size(), 400, ok);
      idle(8);
      for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== 8'(exp_q[i])) bad++;
      checks++; if (!ok || got_q.size() !== exp_q.size() || bad != 0) begin errors++; $display("FAIL stream_full_seq: got %0d bytes with %0d wrong, want %0d", got_q.size(), bad, exp_q.size()); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL stream_full_ovf: got %b want 1", bus.overflow); end
`ifdef STREAM_INPUT_FIFO_STATS_EN
      checks++; if (bus.overflow_count !== 16'd35) begin errors++; $display("FAIL stream_full_count: got %0d want 35", bus.overflow_count); end
`endif
      // One byte every third cycle matches the output rate: no drops, pointers wrap 3 times.
      apply_reset();
      got_q.delete();
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         push(8'(k));
         idle(2);
      end
      wait_q(100, 50, ok);
      idle(4);
      for (int i = 0; i < 100; i++) if (i >= got_q.size() || got_q[i] !== 8'(i)) bad++;
      checks++; if (!ok || got_q.size() !== 100 || bad != 0) begin errors++; $display("FAIL stream_paced_seq: got %0d bytes with %0d wrong, want 0..99", got_q.size(), bad); end
      checks++; if (bus.overflow !== 1'b0 || bus.fifo_level !== 6'd0) begin errors++; $display("FAIL stream_paced_state: got ovf=%b level=%0d want 0 0", bus.overflow, bus.fifo_level); end
   endtask

   initial begin
      reset        = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.ready_n  = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_watermarks();
      test_overflow();
      test_reset_mid();
      test_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
